// File: rtl/sc2_pkg.sv
// Shared definitions for the SC2 block copy engine: FSM states, register
// indices and run-register bit positions.
package sc2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HALT = 2'd1,
    ST_SRC       = 2'd2,
    ST_DST       = 2'd3
  } state_t;

  localparam logic [2:0] REG_RUN    = 3'd0;
  localparam logic [2:0] REG_CONST  = 3'd1;
  localparam logic [2:0] REG_SRC_HI = 3'd2;
  localparam logic [2:0] REG_SRC_LO = 3'd3;
  localparam logic [2:0] REG_DST_HI = 3'd4;
  localparam logic [2:0] REG_DST_LO = 3'd5;
  localparam logic [2:0] REG_WIDTH  = 3'd6;
  localparam logic [2:0] REG_HEIGHT = 3'd7;

  localparam int RUN_SUPP_UPPER = 7;
  localparam int RUN_SUPP_LOWER = 6;
  localparam int RUN_SHIFT      = 5;
  localparam int RUN_CONST_SUB  = 4;
  localparam int RUN_ZERO_SUPP  = 3;
  localparam int RUN_SYNC_E     = 2;
  localparam int RUN_SPAN_DST   = 1;
  localparam int RUN_SPAN_SRC   = 0;

endpackage

// File: rtl/sc2_nibble_shift.sv
// Nibble carry and right-shift path between a captured source byte and the
// destination write, plus per-nibble zero detect of the shifted byte.
module sc2_nibble_shift (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       capture,
  input  logic       shift_en,
  input  logic [7:0] data_in,
  output logic [7:0] shifted,
  output logic       upper_zero,
  output logic       lower_zero
);

  logic [3:0] carry;

  assign shifted    = shift_en ? {carry, data_in[7:4]} : data_in;
  assign upper_zero = (shifted[7:4] == 4'h0);
  assign lower_zero = (shifted[3:0] == 4'h0);

  // Row start wins over capture; the two never coincide in practice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry <= 4'h0;
    end else if (clear) begin
      carry <= 4'h0;
    end else if (capture) begin
      carry <= data_in[3:0];
    end
  end

endmodule

// File: rtl/sc2_blitter.sv
// Halt-based DMA rectangle copy engine: CPU programs eight registers, the block
// halts the CPU and alternates read/write bus cycles until the copy completes.
module sc2_blitter
  import sc2_pkg::*;
#(
  parameter logic [15:0] STRIDE   = 16'd256,
  parameter logic [7:0]  SIZE_XOR = 8'h04,
  parameter bit          SHIFT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        e_sync,
  input  logic        reg_cs,
  input  logic [7:0]  reg_data_in,
  input  logic [2:0]  rs,
  output logic        halt,
  input  logic        halt_ack,
  input  logic        blt_ack,
  output logic        read,
  output logic        write,
  output logic [15:0] blt_address_out,
  input  logic [7:0]  blt_data_in,
  output logic [7:0]  blt_data_out,
  output logic        en_upper,
  output logic        en_lower,
  output logic        done,
  output logic [1:0]  state_dbg
);

  // Bus handshake: a read or write cycle is presented on read/write with
  // blt_address_out stable; it completes on any clock where blt_ack is high
  // (and e_sync is high too when run bit sync_e is set), otherwise it holds.

  state_t      state;
  logic [7:0]  run_q, const_q, width_q, height_q, x_q, y_q;
  logic [15:0] src_base, dst_base, src_addr, dst_addr;

  logic        advance, row_end, last_row, nib_clear, nib_capture;
  logic [7:0]  x_next, y_next, shifted, wr_data;
  logic [15:0] src_step_addr, dst_step_addr, src_row_addr, dst_row_addr;
  logic        upper_zero, lower_zero, en_upper_next, en_lower_next;

  assign state_dbg = state;
  assign advance   = blt_ack & (~run_q[RUN_SYNC_E] | e_sync);
  assign x_next    = x_q + 8'd1;
  assign y_next    = y_q + 8'd1;
  assign row_end   = (x_next == width_q);
  assign last_row  = (y_next == height_q);

  assign src_step_addr = src_addr + (run_q[RUN_SPAN_SRC] ? STRIDE : 16'd1);
  assign dst_step_addr = dst_addr + (run_q[RUN_SPAN_DST] ? STRIDE : 16'd1);
  // Span mode restarts each row one byte right of the base; linear mode just continues.
  assign src_row_addr  = run_q[RUN_SPAN_SRC] ? src_base + {8'h00, y_next} : src_addr + 16'd1;
  assign dst_row_addr  = run_q[RUN_SPAN_DST] ? dst_base + {8'h00, y_next} : dst_addr + 16'd1;

  assign nib_capture = (state == ST_SRC) & advance;
  assign nib_clear   = ((state == ST_WAIT_HALT) & halt_ack) |
                       ((state == ST_DST) & advance & row_end);

  sc2_nibble_shift u_shift (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (nib_clear),
    .capture    (nib_capture),
    .shift_en   (SHIFT_EN & run_q[RUN_SHIFT]),
    .data_in    (blt_data_in),
    .shifted    (shifted),
    .upper_zero (upper_zero),
    .lower_zero (lower_zero)
  );

  assign wr_data       = run_q[RUN_CONST_SUB] ? const_q : shifted;
  assign en_upper_next = ~(run_q[RUN_SUPP_UPPER] | (run_q[RUN_ZERO_SUPP] & upper_zero));
  assign en_lower_next = ~(run_q[RUN_SUPP_LOWER] | (run_q[RUN_ZERO_SUPP] & lower_zero));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      run_q           <= 8'h00;
      const_q         <= 8'hFF;
      width_q         <= 8'h00;
      height_q        <= 8'h00;
      src_base        <= 16'h0000;
      dst_base        <= 16'h0000;
      src_addr        <= 16'h0000;
      dst_addr        <= 16'h0000;
      x_q             <= 8'h00;
      y_q             <= 8'h00;
      halt            <= 1'b0;
      read            <= 1'b0;
      write           <= 1'b0;
      done            <= 1'b0;
      blt_address_out <= 16'h0000;
      blt_data_out    <= 8'h00;
      en_upper        <= 1'b1;
      en_lower        <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (reg_cs) begin
            case (rs)
              REG_RUN: begin
                run_q <= reg_data_in;
                halt  <= 1'b1;
                state <= ST_WAIT_HALT;
              end
              REG_CONST:  const_q        <= reg_data_in;
              REG_SRC_HI: src_base[15:8] <= reg_data_in;
              REG_SRC_LO: src_base[7:0]  <= reg_data_in;
              REG_DST_HI: dst_base[15:8] <= reg_data_in;
              REG_DST_LO: dst_base[7:0]  <= reg_data_in;
              REG_WIDTH:  width_q        <= reg_data_in ^ SIZE_XOR;
              REG_HEIGHT: height_q       <= reg_data_in ^ SIZE_XOR;
            endcase
          end
        end
        ST_WAIT_HALT: begin
          if (halt_ack) begin
            if (width_q == 8'h00 || height_q == 8'h00) begin
              halt  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              src_addr        <= src_base;
              dst_addr        <= dst_base;
              x_q             <= 8'h00;
              y_q             <= 8'h00;
              read            <= 1'b1;
              blt_address_out <= src_base;
              state           <= ST_SRC;
            end
          end
        end
        ST_SRC: begin
          if (advance) begin
            read            <= 1'b0;
            write           <= 1'b1;
            blt_address_out <= dst_addr;
            blt_data_out    <= wr_data;
            en_upper        <= en_upper_next;
            en_lower        <= en_lower_next;
            state           <= ST_DST;
          end
        end
        ST_DST: begin
          if (advance) begin
            write    <= 1'b0;
            en_upper <= 1'b1;
            en_lower <= 1'b1;
            if (row_end && last_row) begin
              x_q   <= 8'h00;
              halt  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else if (row_end) begin
              x_q             <= 8'h00;
              y_q             <= y_next;
              src_addr        <= src_row_addr;
              dst_addr        <= dst_row_addr;
              read            <= 1'b1;
              blt_address_out <= src_row_addr;
              state           <= ST_SRC;
            end else begin
              x_q             <= x_next;
              src_addr        <= src_step_addr;
              dst_addr        <= dst_step_addr;
              read            <= 1'b1;
              blt_address_out <= src_step_addr;
              state           <= ST_SRC;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc2_blitter.sv
// Directed bench for sc2_blitter: a memory-backed bus responder, a write
// monitor feeding a scoreboard, and a linear sequence of checked steps.
module tb_sc2_blitter;

  localparam int W = 26;  // {en_upper, en_lower, address[15:0], data[7:0]}
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_SRC = 2'd2, S_DST = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        e_sync, reg_cs, blt_ack;
  logic [7:0]  reg_data_in;
  logic [2:0]  rs;
  wire  logic  halt, read, write, en_upper, en_lower, done, halt_ack;
  wire  logic [15:0] blt_address_out;
  wire  logic [7:0]  blt_data_in, blt_data_out;
  wire  logic [1:0]  state_dbg;

  logic [7:0]   mem [0:65535];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int n_tests = 0, n_fail = 0;
  int rd_cnt = 0, done_cnt = 0, both_cnt = 0, cyc;
  bit sync_mode = 1'b0;

  sc2_blitter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .e_sync          (e_sync),
    .reg_cs          (reg_cs),
    .reg_data_in     (reg_data_in),
    .rs              (rs),
    .halt            (halt),
    .halt_ack        (halt_ack),
    .blt_ack         (blt_ack),
    .read            (read),
    .write           (write),
    .blt_address_out (blt_address_out),
    .blt_data_in     (blt_data_in),
    .blt_data_out    (blt_data_out),
    .en_upper        (en_upper),
    .en_lower        (en_lower),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset / bus responder ----------------
  always #5 clk = ~clk;
  assign halt_ack    = halt;
  assign blt_data_in = read ? mem[blt_address_out] : 8'h00;

  // Monitor samples mid-low-phase, after inputs driven at negedge have settled.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (read && write) both_cnt++;
      if (done) done_cnt++;
      if (blt_ack && (!sync_mode || e_sync)) begin
        if (read) rd_cnt++;
        if (write) obs_q.push_back({en_upper, en_lower, blt_address_out, blt_data_out});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [7:0] data);
    @(negedge clk);
    rs = sel;
    reg_data_in = data;
    reg_cs = 1'b1;
    @(negedge clk);
    reg_cs = 1'b0;
  endtask

  task automatic start_blt(input logic [7:0] w_reg, input logic [7:0] h_reg,
                           input logic [15:0] src, input logic [15:0] dst,
                           input logic [7:0] run);
    reg_write(3'd6, w_reg);
    reg_write(3'd7, h_reg);
    reg_write(3'd2, src[15:8]);
    reg_write(3'd3, src[7:0]);
    reg_write(3'd4, dst[15:8]);
    reg_write(3'd5, dst[7:0]);
    exp_q.delete();
    obs_q.delete();
    rd_cnt = 0;
    done_cnt = 0;
    reg_write(3'd0, run);
  endtask

  task automatic wait_done(input int max_cyc, output int cycles);
    cycles = 0;
    while (!done && cycles < max_cyc) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic push_exp(input logic [1:0] en, input logic [15:0] addr, input logic [7:0] data);
    exp_q.push_back({en, addr, data});
  endtask

  task automatic check_writes(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b1; e_sync = 1'b0; reg_cs = 1'b0; blt_ack = 1'b1;
    reg_data_in = 8'h00; rs = 3'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_halt", halt, 1'b0);
    check("rst_rw", {read, write, done}, 3'b000);
    check("rst_addr", blt_address_out, 16'h0000);
    check("rst_dout", blt_data_out, 8'h00);
    check("rst_en", {en_upper, en_lower}, 2'b11);
    reset_n = 1'b1;

    // 2x1 linear copy
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22;
    start_blt(8'h06, 8'h05, 16'h1000, 16'h2000, 8'h00);
    check("t1_halt_rise", halt, 1'b1);
    wait_done(40, cyc);
    check("t1_cycles", cyc, 5);
    check("t1_halt_fall", halt, 1'b0);
    push_exp(2'b11, 16'h2000, 8'h11);
    push_exp(2'b11, 16'h2001, 8'h22);
    check_writes("t1");
    check("t1_reads", rd_cnt, 2);
    check("t1_done", done_cnt, 1);

    // 3x2 with span destination
    for (int i = 0; i < 6; i++) mem[16'h3000 + i] = 8'h30 + 8'(i);
    start_blt(8'h07, 8'h06, 16'h3000, 16'h4000, 8'h02);
    wait_done(60, cyc);
    check("t2_cycles", cyc, 13);
    push_exp(2'b11, 16'h4000, 8'h30); push_exp(2'b11, 16'h4100, 8'h31);
    push_exp(2'b11, 16'h4200, 8'h32); push_exp(2'b11, 16'h4001, 8'h33);
    push_exp(2'b11, 16'h4101, 8'h34); push_exp(2'b11, 16'h4201, 8'h35);
    check_writes("t2");
    check("t2_reads", rd_cnt, 6);

    // shift right, 3x2; carry restarts at each row
    mem[16'h5000] = 8'hAB; mem[16'h5001] = 8'hCD; mem[16'h5002] = 8'hEF;
    mem[16'h5003] = 8'h12; mem[16'h5004] = 8'h34; mem[16'h5005] = 8'h56;
    start_blt(8'h07, 8'h06, 16'h5000, 16'h6000, 8'h20);
    wait_done(60, cyc);
    push_exp(2'b11, 16'h6000, 8'h0A); push_exp(2'b11, 16'h6001, 8'hBC);
    push_exp(2'b11, 16'h6002, 8'hDE); push_exp(2'b11, 16'h6003, 8'h01);
    push_exp(2'b11, 16'h6004, 8'h23); push_exp(2'b11, 16'h6005, 8'h45);
    check_writes("t3");

    // constant substitution with zero suppress on the source byte
    mem[16'h7000] = 8'h0F;
    reg_write(3'd1, 8'h77);
    start_blt(8'h05, 8'h05, 16'h7000, 16'h7100, 8'h18);
    wait_done(20, cyc);
    check("t4_cycles", cyc, 3);
    push_exp(2'b01, 16'h7100, 8'h77);
    check_writes("t4");

    // suppress_upper and destination wrap past 0xFFFF
    mem[16'h0100] = 8'h5A; mem[16'h0101] = 8'hA5;
    start_blt(8'h06, 8'h05, 16'h0100, 16'hFFFF, 8'h80);
    wait_done(20, cyc);
    push_exp(2'b01, 16'hFFFF, 8'h5A);
    push_exp(2'b01, 16'h0000, 8'hA5);
    check_writes("t4b");

    // zero width: handshake only
    start_blt(8'h04, 8'h05, 16'h1000, 16'h2000, 8'h00);
    check("t5_halt_rise", halt, 1'b1);
    wait_done(20, cyc);
    check("t5_cycles", cyc, 1);
    check("t5_halt_fall", halt, 1'b0);
    check_writes("t5");
    check("t5_reads", rd_cnt, 0);
    check("t5_done", done_cnt, 1);

    // E-clock sync: ack held high, progress only on e_sync
    sync_mode = 1'b1;
    mem[16'h0800] = 8'h3C;
    start_blt(8'h05, 8'h05, 16'h0800, 16'h0900, 8'h04);
    @(negedge clk);
    check("t6_enter_src", state_dbg, S_SRC);
    reg_write(3'd7, 8'h00);  // height write while busy must be ignored
    check("t6_hold_src", {state_dbg, read}, {S_SRC, 1'b1});
    e_sync = 1'b1;
    @(negedge clk);
    e_sync = 1'b0;
    check("t6_to_dst", {state_dbg, write}, {S_DST, 1'b1});
    repeat (3) @(negedge clk);
    check("t6_hold_dst", state_dbg, S_DST);
    e_sync = 1'b1;
    @(negedge clk);
    e_sync = 1'b0;
    check("t6_to_idle", {state_dbg, done, halt}, {S_IDLE, 1'b1, 1'b0});
    push_exp(2'b11, 16'h0900, 8'h3C);
    check_writes("t6");
    check("t6_reads", rd_cnt, 1);
    sync_mode = 1'b0;

    // asynchronous reset in the middle of a BLT
    start_blt(8'h07, 8'h06, 16'h3000, 16'h4000, 8'h00);
    repeat (4) @(negedge clk);
    check("t7_busy", halt, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t7_halt_drop", halt, 1'b0);
    check("t7_rw", {read, write, done}, 3'b000);
    check("t7_state", state_dbg, S_IDLE);
    check("t7_addr_en", {blt_address_out, en_upper, en_lower}, {16'h0000, 2'b11});
    @(negedge clk);
    reset_n = 1'b1;

    // constant register is back at 0xFF after reset
    mem[16'h0200] = 8'h12;
    start_blt(8'h05, 8'h05, 16'h0200, 16'h0300, 8'h10);
    wait_done(20, cyc);
    check("t8_cycles", cyc, 3);
    push_exp(2'b11, 16'h0300, 8'hFF);
    check_writes("t8");

    check("rw_exclusive", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
